sincos_cordic_gen: RTL and testbench
====================================

// Module: sincos_cordic_gen
// PURPOSE
//  Iterative CORDIC source of the signed Q8.8 sin/cos pair (1.0 = 16'sd256) that the
//  vertex rotation stage consumes. Accepts a binary angle on a valid/ready handshake
//  and returns the cos/sin pair after a fixed latency. The result is held stable until
//  the consumer takes it, so the rotation stage sees constant sin/cos for a whole frame.
// PARAMETERS
//  ANGLE_W  10  angle width; one LSB = 2*pi/2**ANGLE_W; full circle = 2**ANGLE_W
//  ITER     12  CORDIC iterations (range 8..16)
//  IW       20  internal signed x/y datapath width; Q2.(IW-4) with 2 guard bits
// PORTS
//  clk_in     in   1        system clock
//  rst_n_in   in   1        asynchronous, active-low reset
//  angle_in   in   ANGLE_W  unsigned binary angle
//  in_valid   in   1        angle_in is valid
//  in_ready   out  1        block is ready to accept an angle (high only in IDLE)
//  cos_out    out  16       signed Q8.8 cos, clamped to [-256, 256]
//  sin_out    out  16       signed Q8.8 sin, clamped to [-256, 256]
//  out_valid  out  1        cos_out and sin_out are valid
//  out_ready  in   1        consumer accepts the result
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, cos_out=0, sin_out=0, out_valid=0,
//    in_ready=1. Reset asserted mid-computation aborts the operation. No result is emitted.
//  - FSM IDLE -> RUN on in_valid&&in_ready. RUN -> DONE after ITER iteration cycles.
//    DONE -> IDLE on out_ready.
//  - in_ready = (state==IDLE). Decode it from state only; no combinational path from
//    out_ready.
//  - Accept at edge N: latch q = angle_in[ANGLE_W-1 -: 2] and r = remaining bits.
//    Init x = K (0.607253 * 2**(IW-4), rounded), y = 0, z = r << 8.
//  - Iteration i = 0..ITER-1, one per cycle: d = (z>=0)?+1:-1.
//    x -= d*(y>>>i); y += d*(x>>>i); z -= d*ATAN[i]. Updates use the previous x and y.
//  - ATAN[i] = round(atan(2**-i) / (2*pi) * 2**(ANGLE_W+8)). Generate it as a localparam
//    table; ATAN[0] = 2**(ANGLE_W+5).
//  - Quadrant unfold (c=x, s=y): q0:(c,s); q1:(-s,c); q2:(-c,-s); q3:(s,-c).
//  - Scale from Q2.(IW-4) to Q8.8 with an arithmetic right shift of IW-12.
//  - Clamp to [-256, 256], then register into cos_out/sin_out. out_valid rises at edge
//    N+ITER+1.
//  - DONE: outputs and out_valid hold while out_ready=0. When out_ready=1 in DONE,
//    out_valid drops at the next edge.
//  - cos_out and sin_out keep their last value after the handshake; only out_valid
//    clears. No new accept is possible in the DONE-exit cycle, because in_ready is still 0.
//  - in_valid during RUN or DONE is ignored. The upstream holds angle_in until it is accepted.
//  - Boundary angles: angle 0 -> (256,0); 2**(ANGLE_W-2) -> (0,256); 2**(ANGLE_W-1) -> (-256,0);
//    3*2**(ANGLE_W-2) -> (0,-256). Each is within +-1 LSB before clamping, and exact after
//    the clamp where the clamp applies.
//  - The angle wraps naturally: 2**ANGLE_W-1 is just below a full circle.
//    Result: cos ~ 256, sin = -2 +-1 (ANGLE_W=10).
// CONFIGURATION
//  SINCOS_ROUND_EN defined: the final scale shift rounds half away from zero
//    (add +/-2**(IW-13) before the shift).
//  SINCOS_ROUND_EN undefined: the final shift truncates (arithmetic >>>). Truncation
//    toward -inf has a bias of up to 1 LSB.
//  Latency, handshake and clamp behaviour are identical in both builds.
// TESTING
//  1. angle_in=0, in_valid pulse, out_ready=1 -> out_valid at accept+ITER+1;
//     cos_out=256, sin_out=0 (+-1).
//  2. angle_in=128 (pi/4) -> cos_out=181, sin_out=181 (+-1).
//     angle_in=256 -> cos_out=0 (+-1), sin_out=256.
//  3. angle_in=768 -> cos_out=0, sin_out=-256. angle_in=512 -> cos_out=-256, sin_out=0.
//     Check sign handling in every quadrant.
//  4. Backpressure: out_ready=0 for 20 cycles -> out_valid and outputs stable, in_ready=0.
//     Raise out_ready -> out_valid=0 next edge, in_ready=1.
//  5. Reset mid-RUN (rst_n_in=0 at accept+5) -> out_valid=0, outputs 0, in_ready=1
//     immediately. Next accept of angle 256 completes normally.
//  6. Sweep all 1024 angles against a real-valued model: error <= 1 LSB with
//     SINCOS_ROUND_EN, <= 2 LSB without. Also check |cos|, |sin| <= 256.

Source files
------------

// File: rtl/sincos_cordic_gen_if.sv
// Angle request / Q8.8 cos-sin response handshake bundle for sincos_cordic_gen.
interface sincos_cordic_gen_if #(
    parameter int ANGLE_W = 10
);
    logic [ANGLE_W-1:0] angle_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] cos_out;
    logic signed [15:0] sin_out;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output angle_in, in_valid, out_ready,
        input  in_ready, cos_out, sin_out, out_valid
    );
    modport slave (
        input  angle_in, in_valid, out_ready,
        output in_ready, cos_out, sin_out, out_valid
    );
endinterface

// File: rtl/sincos_cordic_gen.sv
// Iterative CORDIC sin/cos generator, binary angle in, clamped Q8.8 cos/sin out.
// Build option SINCOS_ROUND_EN: final scale shift rounds half away from zero instead of truncating.
module sincos_cordic_gen #(
    parameter int ANGLE_W = 10,
    parameter int ITER    = 12,
    parameter int IW      = 20
) (
    input logic                clk_in,
    input logic                rst_n_in,
    sincos_cordic_gen_if.slave bus
);
    localparam int ZW = ANGLE_W + 8;
    localparam int CW = $clog2(ITER + 1);
    localparam int SH = IW - 12;
    localparam logic signed [IW-1:0] K_INIT = IW'($rtoi(0.607253 * (2.0 ** (IW - 4)) + 0.5));
    localparam logic signed [IW-1:0] LIM    = IW'(256);
`ifdef SINCOS_ROUND_EN
    localparam logic signed [IW-1:0] HALF   = IW'(1) <<< (SH - 1);
`endif

    // z counts in 2**(ANGLE_W+8) units per full circle, so one angle LSB = 256 z LSBs
    function automatic logic [ITER-1:0][ZW-1:0] gen_atan();
        logic [ITER-1:0][ZW-1:0] t;
        real rad;
        t = '0;
        for (int i = 0; i < ITER; i++) begin
            case (i)
                0:  rad = 0.7853981633974483;
                1:  rad = 0.4636476090008061;
                2:  rad = 0.24497866312686414;
                3:  rad = 0.12435499454676144;
                4:  rad = 0.06241880999595735;
                5:  rad = 0.031239833430268277;
                6:  rad = 0.015623728620476831;
                7:  rad = 0.007812341060101111;
                8:  rad = 0.0039062301319669718;
                9:  rad = 0.0019531225164788188;
                10: rad = 0.0009765621895593195;
                11: rad = 0.0004882812111948983;
                12: rad = 0.00024414062014936177;
                13: rad = 0.00012207031189367021;
                14: rad = 0.00006103515617420877;
                15: rad = 0.000030517578115526096;
                default: rad = 2.0 ** (-i);
            endcase
            t[i] = ZW'($rtoi(rad / (2.0 * 3.141592653589793) * (2.0 ** ZW) + 0.5));
        end
        return t;
    endfunction

    localparam logic [ITER-1:0][ZW-1:0] ATAN = gen_atan();

    function automatic logic signed [15:0] scale_clamp(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] sc;
`ifdef SINCOS_ROUND_EN
        if (v < 0) sc = -((-v + HALF) >>> SH);
        else       sc = (v + HALF) >>> SH;
`else
        sc = v >>> SH;
`endif
        if (sc > LIM)       sc = LIM;
        else if (sc < -LIM) sc = -LIM;
        return sc[15:0];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt;
    logic [1:0]           quad;
    logic signed [IW-1:0] x, y, xs, ys, x_nxt, y_nxt, c_u, s_u;
    logic signed [ZW-1:0] z, z_nxt, atan_i;
    logic signed [15:0]   cos_q, sin_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = RUN;
            RUN:     if (cnt == CW'(ITER)) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        atan_i = '0;
        for (int i = 0; i < ITER; i++)
            if (cnt == CW'(i)) atan_i = $signed(ATAN[i]);
        xs = x >>> cnt;
        ys = y >>> cnt;
        if (!z[ZW-1]) begin
            x_nxt = x - ys;
            y_nxt = y + xs;
            z_nxt = z - atan_i;
        end else begin
            x_nxt = x + ys;
            y_nxt = y - xs;
            z_nxt = z + atan_i;
        end
    end

    // Rotate the first-quadrant result back out to the quadrant taken from the angle MSBs
    always_comb begin
        c_u = x;
        s_u = y;
        unique case (quad)
            2'd0: begin c_u = x;  s_u = y;  end
            2'd1: begin c_u = -y; s_u = x;  end
            2'd2: begin c_u = -x; s_u = -y; end
            2'd3: begin c_u = y;  s_u = -x; end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt   <= '0;
            quad  <= '0;
            x     <= '0;
            y     <= '0;
            z     <= '0;
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    quad <= bus.angle_in[ANGLE_W-1 -: 2];
                    x    <= K_INIT;
                    y    <= '0;
                    z    <= {2'b00, bus.angle_in[ANGLE_W-3:0], 8'h00};
                    cnt  <= '0;
                end
                RUN: if (cnt == CW'(ITER)) begin
                    cos_q <= scale_clamp(c_u);
                    sin_q <= scale_clamp(s_u);
                end else begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.cos_out   = cos_q;
    assign bus.sin_out   = sin_q;
endmodule

// File: tb/tb_sincos_cordic_gen.sv
// Scoreboard bench for sincos_cordic_gen: directed quadrant/boundary angles, backpressure, reset, full sweep.
module tb_sincos_cordic_gen;
    localparam int ANGLE_W = 10;
    localparam int ITER    = 12;
    localparam int IW      = 20;
`ifdef SINCOS_ROUND_EN
    localparam int SWEEP_TOL = 1;
`else
    localparam int SWEEP_TOL = 2;
`endif

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;

    sincos_cordic_gen_if #(.ANGLE_W(ANGLE_W)) bus ();

    sincos_cordic_gen #(.ANGLE_W(ANGLE_W), .ITER(ITER), .IW(IW)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int angle;
        int cos_e;
        int sin_e;
        int tol;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp, input int tol);
        n_chk++;
        if ((got - exp <= tol) && (exp - got <= tol)) n_pass++;
        else $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, got, exp, tol);
    endtask

    function automatic int rnd(input real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    task automatic send(input int a, input int tol);
        exp_t e;
        real  th;
        int   w;
        th      = 2.0 * 3.141592653589793 * a / (2.0 ** ANGLE_W);
        e.angle = a;
        e.cos_e = rnd(256.0 * $cos(th));
        e.sin_e = rnd(256.0 * $sin(th));
        e.tol   = tol;
        bus.angle_in = ANGLE_W'(a);
        bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk_in); #1;
            w++;
        end
        if (!bus.in_ready) begin
            chk($sformatf("accept_timeout_a%0d", a), 0, 1, 0);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk_in); #1;
        bus.in_valid = 1'b0;
        sb.push_back(e);
    endtask

    task automatic recv(input string tag, input bit chk_lat, input bit chk_rng);
        exp_t e;
        int   k;
        k = 0;
        while (!bus.out_valid && k < 100) begin
            @(posedge clk_in); #1;
            k++;
        end
        if (!bus.out_valid) begin
            chk({tag, "_timeout"}, 0, 1, 0);
            return;
        end
        if (chk_lat) chk({tag, "_latency"}, k, ITER + 1, 0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1, 0);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_cos"}, int'(bus.cos_out), e.cos_e, e.tol);
        chk({tag, "_sin"}, int'(bus.sin_out), e.sin_e, e.tol);
        if (chk_rng)
            chk({tag, "_range"},
                int'((bus.cos_out <= 16'sd256) && (bus.cos_out >= -16'sd256) &&
                     (bus.sin_out <= 16'sd256) && (bus.sin_out >= -16'sd256)), 1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] c0, s0;
        bit stable;

        bus.angle_in  = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst_in_ready",  int'(bus.in_ready),  1, 0);
        chk("rst_out_valid", int'(bus.out_valid), 0, 0);
        chk("rst_cos",       int'(bus.cos_out),   0, 0);
        chk("rst_sin",       int'(bus.sin_out),   0, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;

        // directed quadrant and boundary angles
        send(0,    1); recv("a0",    1, 1);
        send(128,  1); recv("a128",  1, 1);
        send(256,  1); recv("a256",  1, 1);
        send(512,  1); recv("a512",  1, 1);
        send(768,  1); recv("a768",  1, 1);
        send(384,  1); recv("a384",  0, 1);
        send(640,  1); recv("a640",  0, 1);
        send(896,  1); recv("a896",  0, 1);
        send(1023, 1); recv("a1023", 0, 1);

        // backpressure: result must hold, stray in_valid must be ignored
        @(posedge clk_in); #1;
        bus.out_ready = 1'b0;
        send(640, 1); recv("bp", 1, 0);
        c0 = bus.cos_out;
        s0 = bus.sin_out;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = (i == 5);
            bus.angle_in = ANGLE_W'(100);
            @(posedge clk_in); #1;
            if (!bus.out_valid || bus.in_ready || bus.cos_out != c0 || bus.sin_out != s0)
                stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        chk("bp_stable", int'(stable), 1, 0);
        bus.out_ready = 1'b1;
        @(posedge clk_in); #1;
        chk("bp_out_valid_drop", int'(bus.out_valid), 0, 0);
        chk("bp_in_ready",       int'(bus.in_ready),  1, 0);
        chk("bp_cos_hold",       int'(bus.cos_out),   int'(c0), 0);
        chk("bp_sin_hold",       int'(bus.sin_out),   int'(s0), 0);
        chk("bp_no_stray_accept", sb.size(), 0, 0);

        // reset five edges into a computation
        send(512, 1);
        repeat (5) @(posedge clk_in);
        #1;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_out_valid", int'(bus.out_valid), 0, 0);
        chk("midrst_in_ready",  int'(bus.in_ready),  1, 0);
        chk("midrst_cos",       int'(bus.cos_out),   0, 0);
        chk("midrst_sin",       int'(bus.sin_out),   0, 0);
        sb.delete();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        send(256, 1); recv("post_rst", 1, 0);

        // full-circle sweep against the real-valued model
        for (int a = 0; a < (1 << ANGLE_W); a++) begin
            send(a, SWEEP_TOL);
            recv($sformatf("sweep_a%0d", a), 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
